seq_divider: RTL and testbench



---
 rtl/arith_pkg.sv | 5 +
 rtl/div_step.sv | 22 ++
 rtl/seq_divider.sv | 80 ++++++++
 tb/tb_seq_divider.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and default width for the arithmetic units
package arith_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step, ripple subtract via inverted B and carry-in 1
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   r,
  input  logic [W-1:0] d,
  output logic [W:0]   r_next,
  output logic         q
);
  logic [W:0]   b;
  logic [W:0]   s;
  logic [W+1:0] c;
  assign b    = ~{1'b0, d};
  assign c[0] = 1'b1;
  for (genvar i = 0; i <= W; i++) begin : g_fa
    assign s[i]   = r[i] ^ b[i] ^ c[i];
    assign c[i+1] = (r[i] & b[i]) | (c[i] & (r[i] ^ b[i]));
  end
  // carry-out set means no borrow, so the subtraction is kept
  assign q      = c[W+1];
  assign r_next = q ? s : r;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   r_nx;
  logic             qb;
  logic [WIDTH-1:0] q_nx;
  div_step #(.W(WIDTH)) u_step (
    .r      ({r[WIDTH-1:0], q[WIDTH-1]}),
    .d      (dvs),
    .r_next (r_nx),
    .q      (qb)
  );
  assign q_nx = {q[WIDTH-2:0], qb};
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (start && state != RUN) begin
      dvs <= Divisor;
      if (Divisor == '0) begin
        state       <= DONE;
        Quotient    <= '1;
        Remainder   <= Dividend;
        div_by_zero <= 1'b1;
        busy        <= 1'b0;
        done        <= 1'b1;
      end else begin
        state <= RUN;
        r     <= '0;
        q     <= Dividend;
        cnt   <= CW'(WIDTH);
        busy  <= 1'b1;
        done  <= 1'b0;
      end
    end else if (state == RUN) begin
      r   <= r_nx;
      q   <= q_nx;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state       <= DONE;
        Quotient    <= q_nx;
        Remainder   <= r_nx[WIDTH-1:0];
        div_by_zero <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
      end
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and exhaustive checks of seq_divider with a result scoreboard
module tb_seq_divider;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] Dividend = '0;
  logic [3:0] Divisor = '0;
  logic [3:0] Quotient;
  logic [3:0] Remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  typedef struct packed {logic [3:0] q; logic [3:0] r; logic z;} exp_t;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   bcnt;

  seq_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive a request for one edge and push the reference result
  task automatic go(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.q = (b == 0) ? 4'hf : a / b;
    e.r = (b == 0) ? a : a % b;
    e.z = (b == 0);
    sb.push_back(e);
    start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // wait (bounded) for done, counting cycles and busy cycles, then score the result
  task automatic wait_done(input string tag, output int n, output int bc);
    exp_t e;
    n  = 0;
    bc = 0;
    while (!done && n < 20) begin
      bc += int'(busy);
      @(negedge clk);
      n++;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
    else begin
      e = sb.pop_front();
      chk({tag, "_q"}, Quotient, e.q);
      chk({tag, "_r"}, Remainder, e.r);
      chk({tag, "_dz"}, div_by_zero, e.z);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);

    go(13, 4);
    chk("13_4_busy0", busy, 1);
    wait_done("13_4", lat, bcnt);
    chk("13_4_latency", lat + 1, 5);
    chk("13_4_busycycles", bcnt, 4);
    @(negedge clk);
    chk("13_4_done_pulse", done, 0);

    go(15, 1);  wait_done("15_1", lat, bcnt);  @(negedge clk);
    go(7, 9);   wait_done("7_9", lat, bcnt);   @(negedge clk);
    go(15, 15); wait_done("15_15", lat, bcnt); @(negedge clk);
    go(0, 5);   wait_done("0_5", lat, bcnt);   @(negedge clk);

    go(9, 0);
    wait_done("9_0", lat, bcnt);
    chk("9_0_latency", lat + 1, 1);
    chk("9_0_busy", bcnt, 0);
    @(negedge clk);
    chk("9_0_done_pulse", done, 0);
    go(8, 2);
    wait_done("8_2", lat, bcnt);
    @(negedge clk);

    go(6, 3);
    start    = 1'b1;
    Dividend = 15;
    Divisor  = 2;
    @(negedge clk);
    start = 1'b0;
    wait_done("6_3_ign", lat, bcnt);
    lat = 0;
    repeat (8) begin
      @(negedge clk);
      lat += int'(done);
    end
    chk("6_3_single_done", lat, 0);

    go(10, 5);
    wait_done("10_5", lat, bcnt);
    go(11, 3);
    chk("b2b_no_idle", busy, 1);
    wait_done("11_3", lat, bcnt);
    @(negedge clk);

    go(14, 3);
    @(negedge clk);
    rst      = 1'b1;
    start    = 1'b1;
    Dividend = 7;
    Divisor  = 0;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    void'(sb.pop_front());
    chk("mid_rst_q", Quotient, 0);
    chk("mid_rst_r", Remainder, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_dz", div_by_zero, 0);
    @(negedge clk);
    chk("mid_rst_idle", busy | done, 0);
    go(14, 3);
    wait_done("14_3_after_rst", lat, bcnt);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        go(4'(a), 4'(b));
        wait_done("sweep", lat, bcnt);
        chk("sweep_latency", lat + 1, (b == 0) ? 1 : 5);
      end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
